// File: rtl/data_mem_bytewise_pkg.sv
// rtl/data_mem_bytewise_pkg.sv - shared types and constants for the bytewise data memory
// Optional feature macro used by the bundle: MISALIGN_TRAP_EN.
package data_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Index field is sized for the largest legal ADDRW; narrower builds zero-extend into it.
  localparam int WBUF_IDXW = 30;

  typedef struct packed {
    logic                 valid;
    logic [WBUF_IDXW-1:0] idx;
    logic [31:0]          data;
    logic [3:0]           mask;
  } wbuf_t;

  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

endpackage

// File: rtl/data_mem_bytewise_if.sv
// rtl/data_mem_bytewise_if.sv - request/response bus of the bytewise data memory
// rsp_err exists only when MISALIGN_TRAP_EN is defined.
interface data_mem_bytewise_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        rsp_err;
`endif
  logic        init_done;

`ifdef MISALIGN_TRAP_EN
  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
`else
  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );
  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
`endif

endinterface

// File: rtl/data_mem_bytewise_lane_align.sv
// rtl/data_mem_bytewise_lane_align.sv - store lane placement and load lane extraction/extension
// Purely combinational; sizes arrive already normalised (11 folded to word).
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lane,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [3:0]  base_mask;
  logic [31:0] ld_shift;

  always_comb begin
    base_mask = 4'b1111;
    if (st_size == SIZE_B) begin
      base_mask = 4'b0001;
    end else if (st_size == SIZE_H) begin
      base_mask = 4'b0011;
    end
    st_mask = base_mask << st_off;
    st_lane = st_wdata << {st_off, 3'b000};
  end

  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    ld_data  = ld_shift;
    if (ld_size == SIZE_B) begin
      ld_data = {{24{~ld_uns & ld_shift[7]}}, ld_shift[7:0]};
    end else if (ld_size == SIZE_H) begin
      ld_data = {{16{~ld_uns & ld_shift[15]}}, ld_shift[15:0]};
    end
  end

endmodule

// File: rtl/data_mem_bytewise.sv
// rtl/data_mem_bytewise.sv - byte/half/word data memory with write buffer, forwarding and zero-init
// MISALIGN_TRAP_EN: misaligned accesses are trapped via rsp_err instead of being force-aligned.
module data_mem_bytewise
  import data_mem_pkg::*;
#(
  parameter int ADDRW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_bytewise_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDRW;

  logic [3:0][7:0] mem [DEPTH];
  logic [31:0]     rd_word_q;

  logic [0:0]       state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  wbuf_t            wbuf_q, wbuf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             ld_err_q, ld_err_d;
  logic [1:0]       ld_size_q, ld_size_d;
  logic [1:0]       ld_off_q, ld_off_d;
  logic             ld_uns_q, ld_uns_d;
  logic [3:0]       fwd_mask_q, fwd_mask_d;
  logic [31:0]      fwd_data_q, fwd_data_d;

  logic             accept, ld_accept, st_accept, misalign;
  logic [1:0]       size_n, off;
  logic [ADDRW-1:0] idx;
  logic [3:0]       st_mask;
  logic [31:0]      st_lane, ld_data, merged;
  logic             mem_we;
  logic [ADDRW-1:0] mem_widx;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_wdata;
  logic             addr_unused;

  assign addr_unused = ^bus.req_addr[31:ADDRW+2];

  assign accept    = bus.req_valid && (state_q == ST_RUN);
  assign size_n    = norm_size(bus.req_size);
  assign idx       = bus.req_addr[ADDRW+1:2];
  assign ld_accept = accept && !bus.req_we;
  assign st_accept = accept && bus.req_we && !misalign;

  // Low address bits are dropped to the access alignment; with trapping enabled the
  // misaligned accesses are discarded anyway, so the same offset serves both builds.
  always_comb begin
    off = bus.req_addr[1:0];
    if (size_n == SIZE_H) begin
      off = {bus.req_addr[1], 1'b0};
    end else if (size_n == SIZE_W) begin
      off = 2'b00;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((size_n == SIZE_H) && bus.req_addr[0]) ||
                    ((size_n == SIZE_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  mem_lane_align u_align (
    .st_size  (size_n),
    .st_off   (off),
    .st_wdata (bus.req_wdata),
    .st_mask  (st_mask),
    .st_lane  (st_lane),
    .ld_size  (ld_size_q),
    .ld_off   (ld_off_q),
    .ld_uns   (ld_uns_q),
    .ld_word  (merged),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDRW'(1);
      if (cnt_q == {ADDRW{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  // The sweep owns the write port during INIT; afterwards it drains the write buffer.
  always_comb begin
    mem_we    = wbuf_q.valid;
    mem_widx  = wbuf_q.idx[ADDRW-1:0];
    mem_wmask = wbuf_q.mask;
    mem_wdata = wbuf_q.data;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wmask = 4'b1111;
      mem_wdata = 32'h0;
    end
  end

  always_comb begin
    wbuf_d       = wbuf_q;
    wbuf_d.valid = 1'b0;
    if (st_accept) begin
      wbuf_d.valid = 1'b1;
      wbuf_d.idx   = WBUF_IDXW'(idx);
      wbuf_d.data  = st_lane;
      wbuf_d.mask  = st_mask;
    end
  end

  always_comb begin
    rsp_valid_d = accept && (!bus.req_we || misalign);
    ld_err_d    = accept && misalign;
    ld_size_d   = ld_accept ? size_n : ld_size_q;
    ld_off_d    = ld_accept ? off : ld_off_q;
    ld_uns_d    = ld_accept ? bus.req_uns : ld_uns_q;
    fwd_mask_d  = fwd_mask_q;
    fwd_data_d  = fwd_data_q;
    if (ld_accept) begin
      fwd_mask_d = (wbuf_q.valid && (wbuf_q.idx == WBUF_IDXW'(idx))) ? wbuf_q.mask : 4'b0000;
      fwd_data_d = wbuf_q.data;
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = fwd_mask_q[b] ? fwd_data_q[b*8 +: 8] : rd_word_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) begin
          mem[mem_widx][b] <= mem_wdata[b*8 +: 8];
        end
      end
    end
    if (ld_accept) begin
      rd_word_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      wbuf_q      <= '0;
      rsp_valid_q <= 1'b0;
      ld_err_q    <= 1'b0;
      ld_size_q   <= SIZE_W;
      ld_off_q    <= 2'b00;
      ld_uns_q    <= 1'b0;
      fwd_mask_q  <= 4'b0000;
      fwd_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbuf_q      <= wbuf_d;
      rsp_valid_q <= rsp_valid_d;
      ld_err_q    <= ld_err_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_uns_q    <= ld_uns_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign bus.req_ready = (state_q == ST_RUN);
  assign bus.init_done = (state_q == ST_RUN);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (rsp_valid_q && !ld_err_q) ? ld_data : 32'h0;
`ifdef MISALIGN_TRAP_EN
  assign bus.rsp_err   = ld_err_q;
`endif

endmodule

// File: tb/tb_data_mem_bytewise.sv
// tb/tb_data_mem_bytewise.sv - directed self-checking bench for data_mem_bytewise (ADDRW = 4)
// Exercises the MISALIGN_TRAP_EN branch when the macro is defined for the build.
module tb_data_mem_bytewise;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  data_mem_bytewise_if bus ();

  data_mem_bytewise #(.ADDRW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_uns   = uns;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Called at a negedge; returns at the next negedge with the request removed.
  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, sz, 1'b0, a, d);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("st_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, sz, uns, a, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'h1);
    chk(tag, bus.rsp_rdata, exp);
`ifdef MISALIGN_TRAP_EN
    chk({tag, "_err"}, {31'b0, bus.rsp_err}, 32'h0);
`endif
  endtask

  // Called right after reset release at a negedge; ends at a negedge.
  task automatic wait_init(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.req_ready && cyc < 100);
    chk(tag, cyc, 32'd16);
    chk({tag, "_done"}, {31'b0, bus.init_done}, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = SZ_W;
    bus.req_uns   = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("rst_init_done", {31'b0, bus.init_done}, 32'h0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;
    wait_init("init_cycles");
    ld("zero_word0", SZ_W, 1'b0, 32'h0, 32'h0000_0000);

    // Lane extraction, the first load forwarded from the buffer
    st(SZ_W, 32'h8, 32'hDEAD_BEEF);
    ld("byte_s_8", SZ_B, 1'b0, 32'h8, 32'hFFFF_FFEF);
    ld("byte_u_b", SZ_B, 1'b1, 32'hB, 32'h0000_00DE);
    ld("half_s_a", SZ_H, 1'b0, 32'hA, 32'hFFFF_DEAD);
    ld("half_u_8", SZ_H, 1'b1, 32'h8, 32'h0000_BEEF);
    ld("byte_s_9", SZ_B, 1'b0, 32'h9, 32'hFFFF_FFBE);
    ld("rsvd_size", 2'b11, 1'b0, 32'h8, 32'hDEAD_BEEF);

    // Back-to-back stores then a merging load
    st(SZ_W, 32'h4, 32'h1122_3344);
    st(SZ_B, 32'h5, 32'h0000_00AA);
    ld("fwd_merge", SZ_W, 1'b0, 32'h4, 32'h1122_AA44);
    ld("merge_array", SZ_W, 1'b0, 32'h4, 32'h1122_AA44);

    st(SZ_W, 32'h40, 32'h1234_5678);
    ld("wrap_fwd", SZ_W, 1'b0, 32'h0, 32'h1234_5678);
    ld("wrap_array", SZ_W, 1'b0, 32'h80, 32'h1234_5678);

`ifdef MISALIGN_TRAP_EN
    drive(1'b0, SZ_W, 1'b0, 32'h6, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mis_ld_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("mis_ld_err", {31'b0, bus.rsp_err}, 32'h1);
    chk("mis_ld_rdata", bus.rsp_rdata, 32'h0);
    drive(1'b1, SZ_W, 1'b0, 32'h2, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mis_st_valid", {31'b0, bus.rsp_valid}, 32'h1);
    chk("mis_st_err", {31'b0, bus.rsp_err}, 32'h1);
    ld("mis_st_dropped", SZ_W, 1'b0, 32'h0, 32'h1234_5678);
    @(negedge clk);
    ld("mis_st_dropped2", SZ_W, 1'b0, 32'h0, 32'h1234_5678);
`else
    ld("align_word_6", SZ_W, 1'b0, 32'h6, 32'h1122_AA44);
    ld("align_half_9", SZ_H, 1'b1, 32'h9, 32'h0000_BEEF);
    st(SZ_W, 32'h2, 32'hCAFE_0001);
    ld("align_st_2", SZ_W, 1'b0, 32'h0, 32'hCAFE_0001);
`endif

    // Reset mid-INIT must restart the sweep from word 0
    st(SZ_W, 32'h0, 32'hFFFF_FFFF);
    st(SZ_W, 32'h3C, 32'hFFFF_FFFF);
    ld("fill_w15", SZ_W, 1'b0, 32'h3C, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ready", {31'b0, bus.req_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_init_ready", {31'b0, bus.req_ready}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst3_done", {31'b0, bus.init_done}, 32'h0);
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    ld("rezero_w0", SZ_W, 1'b0, 32'h0, 32'h0);
    ld("rezero_w15", SZ_W, 1'b0, 32'h3C, 32'h0);

    // Reset with a store sitting in the write buffer
    drive(1'b1, SZ_W, 1'b0, 32'h1C, 32'hCAFE_F00D);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst4_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst4_rdata", bus.rsp_rdata, 32'h0);
    rst_n = 1'b1;
    wait_init("buf_rst_init");
    ld("buf_discard", SZ_W, 1'b0, 32'h1C, 32'h0);
    @(negedge clk);
    ld("buf_discard2", SZ_H, 1'b1, 32'h1E, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
